stdp_array: RTL and testbench
=============================

STDP_ARRAY -- requirements
Module: stdp_array

Interface
REQ-001 SHALL expose parameter N_PRE, default 5: number of presynaptic LIF channels (1..16).
REQ-002 SHALL expose parameter V_W, default 8: membrane state width for all neurons.
REQ-003 SHALL expose parameter W_W, default 8: synaptic weight width.
REQ-004 SHALL expose parameter T_W, default 4: spike-timing counter width; T_MAX = 2^T_W-1.
REQ-005 SHALL expose parameter W_INIT, default 32: reset value of every weight.
REQ-006 SHALL expose parameter THR_POST, default 200: postsynaptic threshold.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 current  input  8  input current shared by all presynaptic neurons.
REQ-010 thr_pre  input  N_PRE*V_W  packed per-channel thresholds; channel i occupies bits [i*V_W +: V_W].
REQ-011 learn_en  input  1  enables weight updates while high.
REQ-012 w_sel  input  max(1,ceil(log2 N_PRE))  weight readback index.
REQ-013 spike_pre  output  N_PRE  registered presynaptic spikes.
REQ-014 spike_post  output  1  registered postsynaptic spike.
REQ-015 v_post  output  V_W  postsynaptic membrane state.
REQ-016 w_out  output  W_W  weight[w_sel], combinational from registers; an out-of-range index SHALL return 0.
REQ-017 w_upd  output  1  one-cycle pulse set when any weight register changed value on the previous edge.

Function
REQ-018 Each presynaptic neuron SHALL compute v_next = (v>>1) + current in V_W+1 bits, saturated to 2^V_W-1.
REQ-019 If v_next >= thr_pre[i], the neuron SHALL register spike_pre[i]=1 and v=0; otherwise spike_pre[i]=0 and v=v_next. thr=0 fires every cycle.
REQ-020 Synaptic sum SHALL be the sum of weight[i] over all i with spike_pre[i]=1 in the current cycle, saturated to 2^V_W-1.
REQ-021 The post neuron SHALL apply REQ-018/019 with the synaptic sum as current and THR_POST as threshold; its effective latency is one cycle from spike_pre to its contribution.
REQ-022 Each channel SHALL hold a pre-timing counter cpre[i]: 0 on the edge after spike_pre[i]=1, else incremented, saturating at T_MAX.
REQ-023 A post-timing counter cpost SHALL behave identically, keyed on spike_post.
REQ-024 LTP: when learn_en=1 and spike_post=1, every weight[i] SHALL be increased by T_MAX-dt, where dt=0 if spike_pre[i]=1 in the same cycle, else dt=cpre[i]; the result saturates at 2^W_W-1.
REQ-025 dt=T_MAX yields a zero change.
REQ-026 Simultaneous spike_pre[i] and spike_post SHALL apply LTP only for channel i.
REQ-027 All weight changes SHALL be visible on w_out one edge after the triggering spike cycle.
REQ-028 learn_en=0 SHALL freeze all weights; timing counters keep running.

Reset
REQ-029 While rst=1, on each edge: all membrane states=0, spike_pre=0, spike_post=0, v_post=0, cpre/cpost=T_MAX, weights=W_INIT, w_upd=0.
REQ-030 Reset asserted mid-operation SHALL discard any pending update in that cycle; rst has priority over every other event.

Configuration
REQ-031 Macro STDP_LTD_EN defined: LTD SHALL be compiled in. When learn_en=1, spike_pre[i]=1, spike_post=0 and cpost<T_MAX, weight[i] SHALL be decreased by T_MAX-cpost, saturating at 0.
REQ-032 Macro STDP_LTD_EN undefined: there SHALL be no LTD logic, weights SHALL never decrease, and the interface SHALL be unchanged.

Verification
REQ-033 Reset: rst=1 for 2 cycles -> spike_pre=0, spike_post=0, v_post=0, w_out=32 for every w_sel, w_upd=0.
REQ-034 Pre LIF: thr_pre[0]=100, current=60 after reset -> v0 sequence 60, 90, then spike_pre[0]=1 on the 3rd cycle (v_next=105), then v0=0.
REQ-035 Saturation: current=255, thr_pre[0]=255 -> spike_pre[0]=1 every cycle, with no overflow wrap.
REQ-036 LTP: THR_POST=32, W_INIT=32, thr_pre[0]=100, other thresholds max, learn_en=1 -> spike_pre[0] at cycle t, spike_post at t+1 (dt=cpre=0), weight[0]=47 at t+2, w_upd=1 for exactly one cycle.
REQ-037 LTD (STDP_LTD_EN defined): after spike_post at cycle p, spike_pre[0] alone at p+2 (cpost=1) -> weight[0] decreases by 14; without the macro it is unchanged.
REQ-038 Clamp/freeze: W_INIT=250, repeated LTP -> weight stops at 255 and w_upd stays 0 once clamped; with learn_en=0, weights are constant under any spiking.

Source files
------------

// File: rtl/stdp_array.sv
`timescale 1ns/1ps
// stdp_array: N_PRE leaky integrate-and-fire inputs feeding one LIF output through
// STDP-trained weights. Define STDP_LTD_EN to compile in depression (LTD).
module stdp_array #(
  parameter int N_PRE    = 5,
  parameter int V_W      = 8,
  parameter int W_W      = 8,
  parameter int T_W      = 4,
  parameter int W_INIT   = 32,
  parameter int THR_POST = 200,
  localparam int SEL_W   = (N_PRE > 1) ? $clog2(N_PRE) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           current_i,
  input  logic [N_PRE*V_W-1:0] thr_pre_i,
  input  logic                 learn_en_i,
  input  logic [SEL_W-1:0]     w_sel_i,
  output logic [N_PRE-1:0]     spike_pre_o,
  output logic                 spike_post_o,
  output logic [V_W-1:0]       v_post_o,
  output logic [W_W-1:0]       w_out_o,
  output logic                 w_upd_o
);

  localparam int CW = (V_W > 8) ? V_W : 8;
  localparam int AW = ((W_W > T_W) ? W_W : T_W) + 1;
  localparam int SW = ((W_W > V_W) ? W_W : V_W) + 5;
  localparam logic [V_W-1:0] V_MAX = {V_W{1'b1}};
  localparam logic [W_W-1:0] W_MAX = {W_W{1'b1}};
  localparam logic [T_W-1:0] T_MAX = {T_W{1'b1}};
  localparam logic [W_W-1:0] W_RST = W_W'(W_INIT);
  localparam logic [V_W-1:0] THR_P = V_W'(THR_POST);

  function automatic logic [V_W-1:0] lif_integrate(input logic [V_W-1:0] v,
                                                   input logic [V_W-1:0] cur);
    logic [V_W:0] s;
    s = (V_W+1)'(v >> 1'b1) + (V_W+1)'(cur);
    return s[V_W] ? V_MAX : s[V_W-1:0];
  endfunction

  function automatic logic [T_W-1:0] timer_next(input logic fire, input logic [T_W-1:0] c);
    if (fire) begin
      return '0;
    end else if (c == T_MAX) begin
      return T_MAX;
    end else begin
      return c + T_W'(1);
    end
  endfunction

  function automatic logic [W_W-1:0] w_add_sat(input logic [W_W-1:0] w, input logic [T_W-1:0] d);
    logic [AW-1:0] s;
    s = AW'(w) + AW'(d);
    return (s > AW'(W_MAX)) ? W_MAX : W_W'(s);
  endfunction

`ifdef STDP_LTD_EN
  function automatic logic [W_W-1:0] w_sub_sat(input logic [W_W-1:0] w, input logic [T_W-1:0] d);
    return (AW'(w) < AW'(d)) ? '0 : W_W'(AW'(w) - AW'(d));
  endfunction
`endif

  logic [N_PRE-1:0][V_W-1:0] v_pre_q, v_pre_d, v_pre_int_s;
  logic [N_PRE-1:0]          spike_pre_q, spike_pre_d;
  logic [V_W-1:0]            v_post_q, v_post_d, v_post_int_s;
  logic                      spike_post_q, spike_post_d;
  logic [N_PRE-1:0][T_W-1:0] cpre_q, cpre_d, dt_s;
  logic [T_W-1:0]            cpost_q, cpost_d;
  logic [N_PRE-1:0][W_W-1:0] w_q, w_d;
  logic                      w_upd_q, w_upd_d;
  logic [V_W-1:0]            cur_pre_s, syn_cur_s;
  logic [SW-1:0]             syn_sum_s;

  // Presynaptic LIF channels sharing one input current
  always_comb begin
    v_pre_d     = '0;
    spike_pre_d = '0;
    v_pre_int_s = '0;
    cur_pre_s   = (CW'(current_i) > CW'(V_MAX)) ? V_MAX : V_W'(current_i);
    for (int i = 0; i < N_PRE; i++) begin
      v_pre_int_s[i] = lif_integrate(v_pre_q[i], cur_pre_s);
      if (v_pre_int_s[i] >= thr_pre_i[i*V_W +: V_W]) begin
        spike_pre_d[i] = 1'b1;
        v_pre_d[i]     = '0;
      end else begin
        spike_pre_d[i] = 1'b0;
        v_pre_d[i]     = v_pre_int_s[i];
      end
    end
  end

  // Postsynaptic neuron driven by the saturated weighted sum of registered pre spikes
  always_comb begin
    syn_sum_s = '0;
    for (int i = 0; i < N_PRE; i++) begin
      if (spike_pre_q[i]) begin
        syn_sum_s = syn_sum_s + SW'(w_q[i]);
      end else begin
        syn_sum_s = syn_sum_s;
      end
    end
    syn_cur_s    = (syn_sum_s > SW'(V_MAX)) ? V_MAX : V_W'(syn_sum_s);
    v_post_int_s = lif_integrate(v_post_q, syn_cur_s);
    if (v_post_int_s >= THR_P) begin
      spike_post_d = 1'b1;
      v_post_d     = '0;
    end else begin
      spike_post_d = 1'b0;
      v_post_d     = v_post_int_s;
    end
    cpost_d = timer_next(spike_post_q, cpost_q);
  end

  // Spike timers and weight plasticity; a coincident pre spike counts as dt=0
  always_comb begin
    w_d    = w_q;
    cpre_d = '0;
    dt_s   = '0;
    for (int i = 0; i < N_PRE; i++) begin
      cpre_d[i] = timer_next(spike_pre_q[i], cpre_q[i]);
      dt_s[i]   = spike_pre_q[i] ? '0 : cpre_q[i];
      if (learn_en_i && spike_post_q) begin
        w_d[i] = w_add_sat(w_q[i], T_MAX - dt_s[i]);
`ifdef STDP_LTD_EN
      end else if (learn_en_i && spike_pre_q[i] && (cpost_q != T_MAX)) begin
        w_d[i] = w_sub_sat(w_q[i], T_MAX - cpost_q);
`endif
      end else begin
        w_d[i] = w_q[i];
      end
    end
    w_upd_d = (w_d != w_q);
  end

  // Weight readback; indices past the last channel read as zero
  always_comb begin
    w_out_o = '0;
    for (int i = 0; i < N_PRE; i++) begin
      if (w_sel_i == SEL_W'(i)) begin
        w_out_o = w_q[i];
      end else begin
        w_out_o = w_out_o;
      end
    end
  end

  // State register; reset overrides any update computed this cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_pre_q      <= '0;
      spike_pre_q  <= '0;
      v_post_q     <= '0;
      spike_post_q <= 1'b0;
      cpre_q       <= {N_PRE{T_MAX}};
      cpost_q      <= T_MAX;
      w_q          <= {N_PRE{W_RST}};
      w_upd_q      <= 1'b0;
    end else begin
      v_pre_q      <= v_pre_d;
      spike_pre_q  <= spike_pre_d;
      v_post_q     <= v_post_d;
      spike_post_q <= spike_post_d;
      cpre_q       <= cpre_d;
      cpost_q      <= cpost_d;
      w_q          <= w_d;
      w_upd_q      <= w_upd_d;
    end
  end

  assign spike_pre_o  = spike_pre_q;
  assign spike_post_o = spike_post_q;
  assign v_post_o     = v_post_q;
  assign w_upd_o      = w_upd_q;

endmodule

// File: tb/tb_stdp_array.sv
`timescale 1ns/1ps
// Directed-vector bench for stdp_array: an integer reference model is stepped on
// every clock edge and all outputs (every w_sel value) are compared each cycle.
module tb_stdp_array;

  localparam int NP    = 5;
  localparam int TMAX  = 15;
  localparam int VMAX  = 255;
  localparam int WMAX  = 255;
  localparam int WINIT = 32;
  localparam int THRP  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      current;
  logic [NP*8-1:0] thr_pre;
  logic            learn_en;
  logic [2:0]      w_sel;
  logic [NP-1:0]   spike_pre;
  logic            spike_post;
  logic [7:0]      v_post;
  logic [7:0]      w_out;
  logic            w_upd;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int            m_v[NP];
  int            m_w[NP];
  int            m_cpre[NP];
  logic [NP-1:0] m_sp;
  int            m_vpost;
  int            m_cpost;
  logic          m_spost;
  logic          m_upd;
  int            saved_w[NP];

  always #10 clk = ~clk;

  stdp_array #(
    .N_PRE(NP), .V_W(8), .W_W(8), .T_W(4), .W_INIT(WINIT), .THR_POST(THRP)
  ) dut (
    .clk_i(clk), .rst_i(rst), .current_i(current), .thr_pre_i(thr_pre),
    .learn_en_i(learn_en), .w_sel_i(w_sel), .spike_pre_o(spike_pre),
    .spike_post_o(spike_post), .v_post_o(v_post), .w_out_o(w_out), .w_upd_o(w_upd)
  );

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // one clock edge of the neuron/learning rules, in plain integers
  task automatic model_step();
    int            nv[NP];
    int            nw[NP];
    int            ncpre[NP];
    logic [NP-1:0] nsp;
    int            sum;
    int            vn;
    int            dt;
    if (rst) begin
      for (int i = 0; i < NP; i++) begin
        m_v[i] = 0; m_w[i] = WINIT; m_cpre[i] = TMAX;
      end
      m_sp = '0; m_vpost = 0; m_spost = 1'b0; m_cpost = TMAX; m_upd = 1'b0;
      return;
    end
    sum = 0;
    for (int i = 0; i < NP; i++) begin
      vn = imin(m_v[i] / 2 + int'(current), VMAX);
      nsp[i] = (vn >= int'(thr_pre[i*8 +: 8]));
      nv[i]  = nsp[i] ? 0 : vn;
      if (m_sp[i]) sum += m_w[i];
      ncpre[i] = m_sp[i] ? 0 : imin(m_cpre[i] + 1, TMAX);
      nw[i] = m_w[i];
      if (learn_en && m_spost) begin
        dt = m_sp[i] ? 0 : m_cpre[i];
        nw[i] = imin(m_w[i] + TMAX - dt, WMAX);
      end
`ifdef STDP_LTD_EN
      else if (learn_en && m_sp[i] && m_cpost < TMAX) begin
        nw[i] = m_w[i] - (TMAX - m_cpost);
        if (nw[i] < 0) nw[i] = 0;
      end
`endif
    end
    sum = imin(sum, VMAX);
    vn = imin(m_vpost / 2 + sum, VMAX);
    m_cpost = m_spost ? 0 : imin(m_cpost + 1, TMAX);
    m_spost = (vn >= THRP);
    m_vpost = m_spost ? 0 : vn;
    m_upd = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (nw[i] != m_w[i]) m_upd = 1'b1;
      m_v[i] = nv[i]; m_w[i] = nw[i]; m_cpre[i] = ncpre[i];
    end
    m_sp = nsp;
  endtask

  task automatic compare_all();
    logic [2:0] keep;
    keep = w_sel;
    chk("spike_pre", int'(spike_pre), int'(m_sp));
    chk("spike_post", int'(spike_post), int'(m_spost));
    chk("v_post", int'(v_post), m_vpost);
    chk("w_upd", int'(w_upd), int'(m_upd));
    for (int s = 0; s < 8; s++) begin
      w_sel = 3'(s);
      #1;
      chk($sformatf("w_out[%0d]", s), int'(w_out), (s < NP) ? m_w[s] : 0);
    end
    w_sel = keep;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wsel_read(input int s, output int val);
    w_sel = 3'(s);
    #1;
    val = int'(w_out);
  endtask

  initial begin
    int v;
    rst = 1'b1; current = 8'd0; thr_pre = {NP{8'd255}}; learn_en = 1'b0; w_sel = 3'd0;
    tick(); tick();
    for (int s = 0; s < 8; s++) begin
      wsel_read(s, v);
      chk($sformatf("rst_w_out[%0d]", s), v, (s < NP) ? 32 : 0);
    end
    chk("rst_spike_pre", int'(spike_pre), 0);
    chk("rst_spike_post", int'(spike_post), 0);
    chk("rst_v_post", int'(v_post), 0);
    chk("rst_w_upd", int'(w_upd), 0);

    // pre LIF: 60, 90, then 105 >= 100 fires
    rst = 1'b0; thr_pre[7:0] = 8'd100; current = 8'd60;
    tick(); chk("lif_c1", int'(spike_pre[0]), 0);
    tick(); chk("lif_c2", int'(spike_pre[0]), 0);
    tick(); chk("lif_c3", int'(spike_pre[0]), 1);
    tick(); chk("lif_post", int'(spike_post), 1);
    chk("lif_frozen_upd", int'(w_upd), 0);

    // LTP: pre fires on tick 3, post on tick 4, weight 32+15 on tick 5
    rst = 1'b1; tick(); rst = 1'b0; learn_en = 1'b1;
    repeat (5) tick();
    wsel_read(0, v);
    chk("ltp_w0", v, 47);
    chk("ltp_upd_on", int'(w_upd), 1);
    tick(); chk("ltp_upd_off", int'(w_upd), 0);
    tick();
    wsel_read(0, v);
`ifdef STDP_LTD_EN
    chk("ltd_w0", v, 33);
`else
    chk("no_ltd_w0", v, 47);
`endif

    // repeated LTP drives weight 0 to its ceiling
    repeat (60) tick();
`ifndef STDP_LTD_EN
    wsel_read(0, v);
    chk("clamp_w0", v, 255);
    chk("clamp_upd", int'(w_upd), 0);
`endif

    // saturated input current fires every channel every cycle
    current = 8'd255; thr_pre = {NP{8'd255}};
    for (int k = 0; k < 3; k++) begin
      tick(); chk($sformatf("sat_spike_%0d", k), int'(spike_pre), 31);
    end

    // learning disabled: weights frozen under continuous spiking
    learn_en = 1'b0;
    for (int i = 0; i < NP; i++) saved_w[i] = m_w[i];
    repeat (8) tick();
    for (int i = 0; i < NP; i++) begin
      wsel_read(i, v);
      chk($sformatf("freeze_w%0d", i), v, saved_w[i]);
    end
    chk("freeze_upd", int'(w_upd), 0);

    // zero threshold fires every cycle even with zero current
    thr_pre = '0; current = 8'd0;
    tick(); tick(); chk("thr0_spike", int'(spike_pre), 31);

    // reset in the middle of learning activity
    learn_en = 1'b1; current = 8'd255; thr_pre = {NP{8'd255}};
    tick(); tick();
    rst = 1'b1; tick();
    wsel_read(0, v);
    chk("midrst_w0", v, 32);
    chk("midrst_spike", int'(spike_pre), 0);
    chk("midrst_upd", int'(w_upd), 0);
    rst = 1'b0; learn_en = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
